// File: rtl/jt08_adpcm_acc_if.sv
// Slot bus between the ADPCM-A gain stage (master) and the six-channel stereo mixer (slave).
interface jt08_adpcm_acc_if;
  logic               cen;
  logic        [5:0]  cur_ch;
  logic        [5:0]  en_ch;
  logic        [1:0]  lr;
  logic signed [15:0] pcm_in;
  logic signed [15:0] pcm_left;
  logic signed [15:0] pcm_right;
  logic               sample;
  logic               ovf;

  modport master (
    output cen, cur_ch, en_ch, lr, pcm_in,
    input  pcm_left, pcm_right, sample, ovf
  );

  modport slave (
    input  cen, cur_ch, en_ch, lr, pcm_in,
    output pcm_left, pcm_right, sample, ovf
  );
endinterface

// File: rtl/jt08_adpcm_acc.sv
// Six-channel ADPCM-A stereo mixer: accumulates one slot per cen, saturates to 16 bits at
// round end and strobes sample for one clk.
module jt08_adpcm_acc #(
  parameter int unsigned ACC_W = 19
) (
  input logic              clk,
  input logic              rst_n,
  jt08_adpcm_acc_if.slave  bus
);

  logic                    w_hit;
  logic signed [ACC_W-1:0] w_pcm_ext;
  logic signed [ACC_W-1:0] w_tl;
  logic signed [ACC_W-1:0] w_tr;
  logic signed [ACC_W-1:0] w_suml;
  logic signed [ACC_W-1:0] w_sumr;
  logic        [ACC_W-16:0] w_topl;
  logic        [ACC_W-16:0] w_topr;
  logic                    w_clipl;
  logic                    w_clipr;
  logic signed [15:0]      w_satl;
  logic signed [15:0]      w_satr;

  logic signed [ACC_W-1:0] r_accl;
  logic signed [ACC_W-1:0] r_accr;
  logic signed [15:0]      r_pcm_left;
  logic signed [15:0]      r_pcm_right;
  logic                    r_sample;
  logic                    r_ovf;

  assign w_hit     = |(bus.en_ch & bus.cur_ch);
  assign w_pcm_ext = {{(ACC_W-16){bus.pcm_in[15]}}, bus.pcm_in};
  assign w_tl      = (bus.lr[1] && w_hit) ? w_pcm_ext : '0;
  assign w_tr      = (bus.lr[0] && w_hit) ? w_pcm_ext : '0;
  assign w_suml    = r_accl + w_tl;
  assign w_sumr    = r_accr + w_tr;

  // The sum fits in 16 bits only when bits [ACC_W-1:15] are all equal.
  assign w_topl  = w_suml[ACC_W-1:15];
  assign w_topr  = w_sumr[ACC_W-1:15];
  assign w_clipl = !((&w_topl) || !(|w_topl));
  assign w_clipr = !((&w_topr) || !(|w_topr));
  assign w_satl  = w_clipl ? (w_suml[ACC_W-1] ? 16'sh8000 : 16'sh7fff) : w_suml[15:0];
  assign w_satr  = w_clipr ? (w_sumr[ACC_W-1] ? 16'sh8000 : 16'sh7fff) : w_sumr[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_accl      <= '0;
      r_accr      <= '0;
      r_pcm_left  <= '0;
      r_pcm_right <= '0;
      r_sample    <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_sample <= 1'b0;
      if (bus.cen) begin
        case (bus.cur_ch)
          6'b000001: begin
            r_accl <= w_tl;
            r_accr <= w_tr;
          end
          6'b000010, 6'b000100, 6'b001000, 6'b010000: begin
            r_accl <= w_suml;
            r_accr <= w_sumr;
          end
          6'b100000: begin
            r_accl      <= '0;
            r_accr      <= '0;
            r_pcm_left  <= w_satl;
            r_pcm_right <= w_satr;
            r_sample    <= 1'b1;
            r_ovf       <= r_ovf | w_clipl | w_clipr;
          end
          // Zero or multi-hot slot indicators are ignored.
          default: ;
        endcase
      end
    end
  end

  assign bus.pcm_left  = r_pcm_left;
  assign bus.pcm_right = r_pcm_right;
  assign bus.sample    = r_sample;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_jt08_adpcm_acc.sv
// Bench for jt08_adpcm_acc: table-driven rounds, hand-written corner sequences and random rounds
// checked against a queue-based mixing model.
module tb_jt08_adpcm_acc;

  logic clk;
  logic rst_n;
  jt08_adpcm_acc_if bus ();

  jt08_adpcm_acc #(.ACC_W(19)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: terms collected since the last round start, plus last published results.
  int   q_l[$];
  int   q_r[$];
  int   exp_l;
  int   exp_r;
  logic exp_ovf;
  logic exp_sample;

  typedef struct {
    logic [5:0]         en;
    logic [1:0]         lr  [6];
    logic signed [15:0] pcm [6];
    int                 want_l;
    int                 want_r;
    logic               want_ovf;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sat16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic int qsum(input int q[$]);
    int s = 0;
    foreach (q[k]) s += q[k];
    return s;
  endfunction

  task automatic model_reset();
    q_l.delete();
    q_r.delete();
    exp_l = 0;
    exp_r = 0;
    exp_ovf = 1'b0;
    exp_sample = 1'b0;
  endtask

  task automatic model_slot(input logic [5:0] ch, input logic [5:0] en, input logic [1:0] lr,
                            input logic signed [15:0] pcm);
    bit enabled = (en & ch) != 6'd0;
    int tl = (lr[1] && enabled) ? int'(pcm) : 0;
    int tr = (lr[0] && enabled) ? int'(pcm) : 0;
    int sl;
    int sr;
    exp_sample = 1'b0;
    if ($countones(ch) != 1) return;
    if (ch == 6'b000001) begin
      q_l.delete();
      q_r.delete();
    end
    q_l.push_back(tl);
    q_r.push_back(tr);
    if (ch == 6'b100000) begin
      sl = qsum(q_l);
      sr = qsum(q_r);
      exp_l = sat16(sl);
      exp_r = sat16(sr);
      if (exp_l != sl || exp_r != sr) exp_ovf = 1'b1;
      exp_sample = 1'b1;
      q_l.delete();
      q_r.delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " pcm_left"},  int'(bus.pcm_left),  exp_l);
    check({tag, " pcm_right"}, int'(bus.pcm_right), exp_r);
    check({tag, " sample"},    int'(bus.sample),    int'(exp_sample));
    check({tag, " ovf"},       int'(bus.ovf),       int'(exp_ovf));
  endtask

  // One cen-high cycle followed by one cen-low cycle.
  task automatic do_slot(input logic [5:0] ch, input logic [5:0] en, input logic [1:0] lr,
                         input logic signed [15:0] pcm);
    @(negedge clk);
    bus.cen    = 1'b1;
    bus.cur_ch = ch;
    bus.en_ch  = en;
    bus.lr     = lr;
    bus.pcm_in = pcm;
    @(posedge clk);
    #1;
    model_slot(ch, en, lr, pcm);
    check_outputs("slot");
    @(negedge clk);
    bus.cen    = 1'b0;
    bus.pcm_in = 16'sh7ffc;
    @(posedge clk);
    #1;
    exp_sample = 1'b0;
    check_outputs("idle");
  endtask

  task automatic stall(input int n);
    @(negedge clk);
    bus.cen    = 1'b0;
    bus.cur_ch = 6'b100000;
    bus.en_ch  = 6'b111111;
    bus.lr     = 2'b11;
    bus.pcm_in = 16'sh4000;
    repeat (n) begin
      @(posedge clk);
      #1;
      exp_sample = 1'b0;
      check_outputs("stall");
    end
  endtask

  task automatic run_vec(input vec_t v);
    for (int i = 0; i < 6; i++) do_slot(6'b1 << i, v.en, v.lr[i], v.pcm[i]);
  endtask

  initial begin
    logic [5:0]         ch;
    logic signed [15:0] p;

    tbl[0].en = 6'b111111;
    tbl[0].lr = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
    tbl[0].pcm = '{16'sd1000, -16'sd400, 16'sd200, 16'sd0, 16'sd0, 16'sd0};
    tbl[0].want_l = 1200;   tbl[0].want_r = -200;   tbl[0].want_ovf = 1'b0;
    tbl[1].en = 6'b101010;
    tbl[1].lr = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    tbl[1].pcm = '{16'sd4000, 16'sd4000, 16'sd4000, 16'sd4000, 16'sd4000, 16'sd4000};
    tbl[1].want_l = 12000;  tbl[1].want_r = 12000;  tbl[1].want_ovf = 1'b0;
    tbl[2] = tbl[1];
    tbl[2].en = 6'b000000;
    tbl[2].want_l = 0;      tbl[2].want_r = 0;
    tbl[3].en = 6'b111111;
    tbl[3].lr = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    tbl[3].pcm = '{16'sd32764, 16'sd32764, 16'sd32764, 16'sd32764, 16'sd32764, 16'sd32764};
    tbl[3].want_l = 32767;  tbl[3].want_r = 32767;  tbl[3].want_ovf = 1'b1;
    tbl[4] = tbl[3];
    tbl[4].pcm = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    tbl[4].want_l = 0;      tbl[4].want_r = 0;
    tbl[5] = tbl[3];
    tbl[5].pcm = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000};
    tbl[5].want_l = -32768; tbl[5].want_r = -32768;

    bus.cen = 1'b0;
    bus.cur_ch = 6'b000001;
    bus.en_ch = 6'b111111;
    bus.lr = 2'b11;
    bus.pcm_in = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-round reset with a nonzero accumulator.
    do_slot(6'b000001, 6'b111111, 2'b11, 16'sd3000);
    do_slot(6'b000010, 6'b111111, 2'b11, 16'sd3000);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) do_slot(6'b1 << i, 6'b111111, 2'b11, 16'sd0);
    check("rst zero round", int'(bus.pcm_left), 0);

    foreach (tbl[t]) begin
      run_vec(tbl[t]);
      check($sformatf("vec%0d left", t),  int'(bus.pcm_left),  tbl[t].want_l);
      check($sformatf("vec%0d right", t), int'(bus.pcm_right), tbl[t].want_r);
      check($sformatf("vec%0d ovf", t),   int'(bus.ovf),       int'(tbl[t].want_ovf));
    end

    // Invalid slots and a cen stall mid-round.
    do_slot(6'b000001, 6'b111111, 2'b11, 16'sd100);
    do_slot(6'b000010, 6'b111111, 2'b10, 16'sd200);
    do_slot(6'b000100, 6'b111111, 2'b11, 16'sd300);
    do_slot(6'b000000, 6'b111111, 2'b11, 16'sd5000);
    do_slot(6'b000011, 6'b111111, 2'b11, 16'sd7000);
    do_slot(6'b001000, 6'b111111, 2'b11, 16'sd400);
    stall(20);
    do_slot(6'b010000, 6'b111111, 2'b11, 16'sd0);
    do_slot(6'b100000, 6'b111111, 2'b11, 16'sd0);
    check("invalid left",  int'(bus.pcm_left),  1000);
    check("invalid right", int'(bus.pcm_right), 800);

    // Random rounds with occasional invalid slots and stalls.
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          ch = 6'($urandom);
          if ($countones(ch) == 1) ch = 6'b000000;
          do_slot(ch, 6'($urandom), 2'($urandom), 16'($urandom) & 16'hfffc);
        end
        if ($urandom_range(0, 9) == 0) stall($urandom_range(1, 6));
        p = 16'($urandom) & 16'hfffc;
        if (r % 2 == 1) p = (p >>> 3) & 16'hfffc;
        do_slot(6'b1 << i, 6'($urandom), 2'($urandom), p);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jt08_adpcm_acc.md
# jt08_adpcm_acc

Six-channel ADPCM-A mixer placed directly after the ADPCM-A gain stage. Each `cen` slot delivers one channel's attenuated sample with its L/R routing bits. The block sums the six channels into separate left and right accumulators, saturates each sum to 16 bits and presents one stereo sample per channel revolution, together with a sample strobe, to the final FM/SSG/ADPCM mixer.

## Interface
Parameters:
- `ACC_W`, 19: accumulator width in bits, signed. Must be ≥19 so that six full-scale samples cannot overflow the accumulator.

Ports:
- `clk`  in  1: system (CPU) clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `cen`  in  1: slot enable, 666 kHz. All state changes only on `clk` edges where `cen`=1.
- `cur_ch`  in  6: one-hot slot indicator, aligned with `pcm_in`/`lr`. Advances 000001→000010→…→100000→000001, one step per `cen`.
- `en_ch`  in  6: channel enable mask. Bit n=0 makes channel n contribute 0.
- `lr`  in  2: routing bits for the current slot. `lr[1]`=left on, `lr[0]`=right on.
- `pcm_in`  in  16 signed: attenuated sample for the current slot.
- `pcm_left`  out  16 signed: saturated left mix.
- `pcm_right`  out  16 signed: saturated right mix.
- `sample`  out  1: pulses for one `clk` when `pcm_left`/`pcm_right` update.
- `ovf`  out  1: sticky flag, set when any output saturated. Cleared only by reset.

## Operation
- Per-slot term:
  - `tl` = `pcm_in` if `lr[1]` and (`en_ch` & `cur_ch`)≠0, else 0.
  - `tr` is defined the same way using `lr[0]`.
  - Both terms are sign-extended to `ACC_W` bits.
- Accumulators `accl` and `accr` are `ACC_W` bits, signed. On a `cen` edge:
  - `cur_ch`=000001 (round start): `acc <= term`. The previous round's content is discarded.
  - `cur_ch` in {000010, 000100, 001000, 010000}: `acc <= acc + term`.
  - `cur_ch`=100000 (round end): `sum = acc + term`. Saturate `sum` to [-32768, 32767] and write the result to `pcm_left`/`pcm_right`. Set `acc <= 0`. Pulse `sample`. If either channel clipped, set `ovf`.
  - Any other `cur_ch` value (zero or multi-hot): accumulators, outputs and `sample` hold, and there is no error.
- Saturation:
  - If `sum` > 32767, output 32767.
  - If `sum` < -32768, output -32768.
  - Otherwise output `sum[15:0]`.
- Input samples arrive with LSBs [1:0] already zero. The mixer does not mask or rescale them; summing preserves that property.
- The gain stage recirculates each channel's value every round, so consecutive rounds normally produce identical outputs. This is required behaviour. Do not gate accumulation on new-data events.

## Timing
- Reset values: `pcm_left`=0, `pcm_right`=0, `sample`=0, `ovf`=0, `accl`=0, `accr`=0.
- Latency: a `pcm_in` presented in slot 100000 appears on the outputs on the same `cen` edge that latches it. A `pcm_in` presented in slot 000001 appears 5 `cen` edges later.
- `sample` is high for exactly one `clk` cycle, the cycle after the round-end `cen` edge. It is low at all other times, including cycles where `cen`=0.
- Outputs change only at round end. Between round ends they are stable for 6 `cen` periods.
- Mid-round reset: all state clears. The first round after reset that starts at 000001 produces a valid sample. A partial round that ends at 100000 without having seen 000001 after reset still outputs the partial sum, which is accepted.
- If `cen` stalls (held low), all state freezes. No timeouts.
- `en_ch`/`lr` changes take effect in the slot where they are sampled. There is no round-level latching.

## Test plan
- Reset: assert `rst_n`=0 mid-round with `accl` nonzero. Then: all outputs 0, `ovf`=0. After release, run one full round of zeros → `pcm_left`=`pcm_right`=0 and `sample` pulses once.
- Routing: ch0=+1000 with lr=10, ch1=-400 with lr=01, ch2=+200 with lr=11, others 0, all enabled → `pcm_left`=1200, `pcm_right`=-200, one `sample` pulse per 6 `cen`.
- Enable mask: all six channels +4000 with lr=11 and `en_ch`=101010 → both outputs 12000. Then `en_ch`=000000 → both outputs 0 on the next round.
- Positive saturation: all channels +32764 with lr=11 → outputs 32767, `ovf`=1. `ovf` stays 1 after a following round of zeros.
- Negative saturation without wrap: all channels -32768 (accumulator total -196608) → outputs -32768. With `ACC_W`=19 the accumulator must show no intermediate sign flip.
- Invalid `cur_ch`: insert 000000 and then 000011 between slots 000100 and 001000 with nonzero `pcm_in` → the sum equals the valid-slot-only sum, and `sample` is unchanged by the inserted slots. Also hold `cen` low for 20 clocks mid-round → outputs and accumulators frozen.
